// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative signed multiply/divide for the EX stage; stalls the front end while iterating.
// Define MULDIV_EARLY_TERM_EN to let MUL stop once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int         WIDTH       = 16,
    parameter logic [1:0] ALUOP_RTYPE = 2'b10,
    parameter logic [3:0] FUNCT_MUL   = 4'b0100,
    parameter logic [3:0] FUNCT_DIV   = 4'b0101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_q, neg_d, sa_q, sa_d, bz_q, bz_d;
    logic [WIDTH-1:0]   a_q, a_d, mp_q, mp_d, lo_q, lo_d, hi_q, hi_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, p;
    logic [WIDTH:0]     dv_q, dv_d, a_ext, b_ext, a_mag, b_mag, t, dsub;
    logic [WIDTH-1:0]   q, r;
    logic               start, last, ge;

    assign a_ext = {op_a[WIDTH-1], op_a};
    assign b_ext = {op_b[WIDTH-1], op_b};
    assign a_mag = op_a[WIDTH-1] ? -a_ext : a_ext;
    assign b_mag = op_b[WIDTH-1] ? -b_ext : b_ext;
    assign start = state_q == IDLE && alu_op == ALUOP_RTYPE && !flush &&
                   (funct_code == FUNCT_MUL || funct_code == FUNCT_DIV);
    assign stall = !rst && (start || state_q == RUN);
    assign done = state_q == DONE;
    assign div_by_zero = done && div_q && bz_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    // Restoring divide: acc holds the partial remainder, mp shifts the dividend out and quotient in.
    assign t = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
    assign dsub = t - dv_q;
    assign ge = t >= dv_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        div_d = div_q;
        neg_d = neg_q;
        sa_d = sa_q;
        bz_d = bz_q;
        a_d = a_q;
        mp_d = mp_q;
        acc_d = acc_q;
        mc_d = mc_q;
        dv_d = dv_q;
        lo_d = lo_q;
        hi_d = hi_q;
`ifdef MULDIV_EARLY_TERM_EN
        last = cnt_q == CW'(WIDTH-1) || (!div_q && mp_q[WIDTH-1:1] == '0);
`else
        last = cnt_q == CW'(WIDTH-1);
`endif
        if (start) begin
            state_d = RUN;
            cnt_d = '0;
            div_d = funct_code == FUNCT_DIV;
            neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            sa_d = op_a[WIDTH-1];
            bz_d = op_b == '0;
            a_d = op_a;
            acc_d = '0;
            mc_d = {{WIDTH{1'b0}}, a_mag[WIDTH-1:0]};
            mp_d = funct_code == FUNCT_DIV ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
            dv_d = b_mag;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
            state_d = last ? DONE : RUN;
            acc_d = div_q ? {{(WIDTH-1){1'b0}}, ge ? dsub : t} : (mp_q[0] ? acc_q + mc_q : acc_q);
            mp_d = div_q ? {mp_q[WIDTH-2:0], ge} : mp_q >> 1;
            mc_d = div_q ? mc_q : mc_q << 1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        if (flush) state_d = IDLE;
        p = neg_q ? -acc_d : acc_d;
        q = neg_q ? -mp_d : mp_d;
        r = sa_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        // Results are committed on entry to DONE so they are valid while done is high.
        if (state_q == RUN && state_d == DONE) begin
            lo_d = div_q ? (bz_q ? '1 : q) : p[WIDTH-1:0];
            hi_d = div_q ? (bz_q ? a_q : r) : p[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            sa_q <= 1'b0;
            bz_q <= 1'b0;
            a_q <= '0;
            mp_q <= '0;
            acc_q <= '0;
            mc_q <= '0;
            dv_q <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            neg_q <= neg_d;
            sa_q <= sa_d;
            bz_q <= bz_d;
            a_q <= a_d;
            mp_q <= mp_d;
            acc_q <= acc_d;
            mc_q <= mc_d;
            dv_q <= dv_d;
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    localparam logic [3:0] MUL = 4'b0100;
    localparam logic [3:0] DIV = 4'b0101;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [1:0] alu_op = 2'b10;
    logic [3:0] funct_code = MUL;
    logic [15:0] op_a = 16'h0003, op_b = 16'h0004;
    logic stall, done, div_by_zero;
    logic [15:0] result_lo, result_hi;
    int pass_cnt = 0, total = 0;

    int cyc, st;
    logic [15:0] lo, hi;
    logic dz, ok;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct_code(funct_code),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        alu_op = 2'b10; funct_code = f; op_a = a; op_b = b;
        cyc = 0; st = 0; ok = 1'b0; lo = 'x; hi = 'x; dz = 'x;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                ok = 1'b1; cyc = n; lo = result_lo; hi = result_hi; dz = div_by_zero;
                break;
            end
            if (stall) st++;
            @(posedge clk); #1;
        end
        alu_op = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
        total++; if ({done, div_by_zero, result_lo, result_hi} !== 34'h0)
            $display("FAIL reset_outputs got %h want 0", {done, div_by_zero, result_lo, result_hi}); else pass_cnt++;
        alu_op = 2'b00; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        issue(MUL, 16'h0007, 16'hFFFD);
        total++; if (!ok || cyc != (ET ? 3 : 17)) $display("FAIL mul1_latency got %0d want %0d", cyc, ET ? 3 : 17); else pass_cnt++;
        total++; if (st != (ET ? 3 : 17)) $display("FAIL mul1_stall_cycles got %0d want %0d", st, ET ? 3 : 17); else pass_cnt++;
        total++; if ({hi, lo} !== 32'hFFFFFFEB) $display("FAIL mul1_result got %h want ffffffeb", {hi, lo}); else pass_cnt++;
        total++; if (dz !== 1'b0) $display("FAIL mul1_dbz got %b want 0", dz); else pass_cnt++;
        total++; if ({stall, done} !== 2'b00) $display("FAIL mul1_after got %b want 00", {stall, done}); else pass_cnt++;
        issue(MUL, 16'h8000, 16'h8000);
        total++; if (!ok || cyc != 17) $display("FAIL mul2_latency got %0d want 17", cyc); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h40000000) $display("FAIL mul2_result got %h want 40000000", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_div;
        issue(DIV, 16'hFFF9, 16'h0002);
        total++; if (!ok || cyc != 17) $display("FAIL div1_latency got %0d want 17", cyc); else pass_cnt++;
        total++; if ({hi, lo} !== 32'hFFFFFFFD) $display("FAIL div1_result got %h want fffffffd", {hi, lo}); else pass_cnt++;
        total++; if (dz !== 1'b0) $display("FAIL div1_dbz got %b want 0", dz); else pass_cnt++;
        issue(DIV, 16'h8000, 16'hFFFF);
        total++; if ({hi, lo} !== 32'h00008000) $display("FAIL div2_result got %h want 00008000", {hi, lo}); else pass_cnt++;
        issue(DIV, 16'h0064, 16'h0007);
        total++; if ({hi, lo} !== 32'h0002000E) $display("FAIL div3_result got %h want 0002000e", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        issue(DIV, 16'h0064, 16'h0000);
        total++; if (!ok || cyc != 17) $display("FAIL dz_latency got %0d want 17", cyc); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h0064FFFF) $display("FAIL dz_result got %h want 0064ffff", {hi, lo}); else pass_cnt++;
        total++; if (dz !== 1'b1) $display("FAIL dz_flag got %b want 1", dz); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL dz_after got %b want 0", div_by_zero); else pass_cnt++;
    endtask

    task automatic test_flush;
        flush = 1'b1; alu_op = 2'b10; funct_code = MUL; op_a = 16'h0005; op_b = 16'h7FFF;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL flush_start_stall got %b want 1", stall); else pass_cnt++;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        total++; if ({stall, done} !== 2'b00) $display("FAIL flush_run got %b want 00", {stall, done}); else pass_cnt++;
        total++; if ({result_hi, result_lo} !== 32'h0064FFFF)
            $display("FAIL flush_hold got %h want 0064ffff", {result_hi, result_lo}); else pass_cnt++;
        flush = 1'b0; alu_op = 2'b00;
        for (int n = 0; n < 20; n++) begin
            total++; if (done !== 1'b0) $display("FAIL flush_no_done got %b want 0 at %0d", done, n); else pass_cnt++;
            @(posedge clk); #1;
        end
        issue(MUL, 16'h0003, 16'h0004);
        total++; if (!ok || cyc != (ET ? 4 : 17)) $display("FAIL flush_next_latency got %0d want %0d", cyc, ET ? 4 : 17); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h0000000C) $display("FAIL flush_next_result got %h want 0000000c", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        alu_op = 2'b10; funct_code = MUL; op_a = 16'h0005; op_b = 16'h7FFF;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if ({stall, done, div_by_zero, result_lo, result_hi} !== 35'h0)
            $display("FAIL rst_mid_run got %h want 0", {stall, done, div_by_zero, result_lo, result_hi}); else pass_cnt++;
        alu_op = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early;
        issue(MUL, 16'h0003, 16'h0002);
        total++; if (!ok || cyc != (ET ? 3 : 17)) $display("FAIL early1_latency got %0d want %0d", cyc, ET ? 3 : 17); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h00000006) $display("FAIL early1_result got %h want 00000006", {hi, lo}); else pass_cnt++;
        issue(MUL, 16'h0005, 16'h0000);
        total++; if (!ok || cyc != (ET ? 2 : 17)) $display("FAIL early2_latency got %0d want %0d", cyc, ET ? 2 : 17); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h00000000) $display("FAIL early2_result got %h want 00000000", {hi, lo}); else pass_cnt++;
        issue(DIV, 16'h0064, 16'h0001);
        total++; if (!ok || cyc != 17) $display("FAIL early_div_latency got %0d want 17", cyc); else pass_cnt++;
        total++; if ({hi, lo} !== 32'h00000064) $display("FAIL early_div_result got %h want 00000064", {hi, lo}); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_flush;
        test_reset_mid_run;
        test_early;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative signed multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched ALU op, funct code and both register operands.
- Stalls the front of the pipeline while it iterates. On completion it delivers a 32-bit result: low/quotient half to the destination register, high/remainder half to R15.
- Single-cycle ALU ops pass by untouched; this block only asserts stall for MUL/DIV.

Parameters:
- WIDTH, 16, operand width; results are 2*WIDTH split into two WIDTH halves.
- ALUOP_RTYPE, 2'b10, alu_op value marking an R-type op.
- FUNCT_MUL, 4'b0100, funct code selecting signed multiply.
- FUNCT_DIV, 4'b0101, funct code selecting signed divide.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_op  input  2  ALU op from the ID/EX register.
- funct_code  input  4  funct code from the ID/EX register.
- op_a  input  WIDTH  first operand (multiplicand / dividend).
- op_b  input  WIDTH  second operand (multiplier / divisor).
- flush  input  1  synchronous abort from hazard/branch logic.
- stall  output  1  holds PC, IF/ID and ID/EX while high.
- done  output  1  one-cycle pulse; results valid.
- result_lo  output  WIDTH  product low half / quotient.
- result_hi  output  WIDTH  product high half / remainder (R15 write).
- div_by_zero  output  1  pulses with done when a DIV had op_b == 0.

Behaviour:
- Reset (async, rst high): state IDLE, counter 0, internal registers 0; done=0, div_by_zero=0, result_lo=0, result_hi=0. stall is forced 0 while rst is high.
- start = state==IDLE & alu_op==ALUOP_RTYPE & funct_code in {FUNCT_MUL, FUNCT_DIV} & ~flush.
- FSM states:
  - IDLE: on start, capture the operand magnitudes, both operand signs and the op type; counter=0; go to RUN.
  - RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. After WIDTH steps go to DONE.
  - DONE: apply sign correction, register the results, done=1 for this cycle, then return to IDLE.
- stall (combinational) = start | state==RUN. stall is low in DONE so the ID/EX register advances at the end of DONE. DONE never accepts start, so the same op cannot retrigger.
- Latency without the optional feature: op visible at cycle 0 → RUN cycles 1..WIDTH → done at cycle WIDTH+1. stall is high for WIDTH+1 cycles.
- MUL arithmetic:
  - Signed two's complement; 2*WIDTH-bit product.
  - Product is negated when the operand signs differ.
  - result_hi is the upper half, result_lo the lower half.
- DIV arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Operand magnitudes use WIDTH+1 bits so that -2^(WIDTH-1) is representable.
  - -32768 / -1 gives quotient 16'h8000 (truncated), remainder 0.
- Divide by zero: result_lo=16'hFFFF, result_hi=op_a as captured, div_by_zero=1 with done. Full RUN latency still applies.
- flush:
  - In any state, the next state is IDLE with no done; result registers keep their previous values.
  - In IDLE, flush blocks start, so stall stays 0 that cycle.
  - In DONE, done still pulses (results already committed).
- result_lo/result_hi hold their values until the next DONE.
- Reset mid-RUN: immediate return to IDLE with all outputs at reset values; the operation is lost.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: MUL leaves RUN after k steps, where k = (index of the highest set bit of |op_b|) + 1, minimum 1 (op_b==0 gives 1 step). stall and done timing shrink accordingly. DIV is unaffected and always takes WIDTH steps.
- Undefined: every op takes exactly WIDTH RUN cycles.

Test Plan:
- MUL 7 × -3 (op_b=16'hFFFD) → after 17 cycles done=1, result_lo=16'hFFEB, result_hi=16'hFFFF; stall high for exactly 17 cycles.
- MUL 16'h8000 × 16'h8000 → result_hi=16'h4000, result_lo=16'h0000.
- DIV -7 / 2 → result_lo=16'hFFFD (-3), result_hi=16'hFFFF (-1), div_by_zero=0. DIV 16'h8000 / 16'hFFFF → result_lo=16'h8000, result_hi=0.
- DIV 100 / 0 → result_lo=16'hFFFF, result_hi=16'h0064, div_by_zero=1 coincident with done.
- flush on RUN cycle 5 → no done, stall low the next cycle; a following MUL 3 × 4 completes normally with result_lo=16'h000C, result_hi=0. Separately, rst raised mid-RUN → all outputs 0 immediately.
- With MULDIV_EARLY_TERM_EN: MUL 3 × 2 → done at cycle 3 (2 RUN cycles), result_lo=16'h0006; MUL 5 × 0 → done at cycle 2, result 0.
